regfile_write_sched: RTL and testbench

//   Write-port scheduler for the 8x16 LC-3 register file. It owns LD_REG/DR/BUS into the file.

---
 rtl/regfile_write_sched_if.sv | 31 +++
 rtl/regfile_write_sched.sv | 109 ++++++++++
 tb/tb_regfile_write_sched.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_sched_if.sv
// Requester and register-file write-port signals of the write scheduler.
// slave  : scheduler side (takes requests, drives the register-file load port)
// master : requester/host side (drives requests, observes the load port)
interface regfile_write_sched_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              clear_req;
  logic              a_valid;
  logic [ADDR_W-1:0] a_dr;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_dr;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              LD_REG;
  logic [ADDR_W-1:0] DR;
  logic [DATA_W-1:0] BUS;
  logic              init_done;

  modport slave (
    input  clear_req, a_valid, a_dr, a_data, b_valid, b_dr, b_data,
    output a_ready, b_ready, LD_REG, DR, BUS, init_done
  );

  modport master (
    output clear_req, a_valid, a_dr, a_data, b_valid, b_dr, b_data,
    input  a_ready, b_ready, LD_REG, DR, BUS, init_done
  );
endinterface

// File: rtl/regfile_write_sched.sv
// Write-port scheduler for the LC-3 register file.
// Zero-clears every register after reset (the file has no reset of its own),
// then round-robins single-cycle writes between the datapath writeback (A)
// and the debug/host port (B). The load port is fully registered.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_CLEAR | sweeping CLEAR_VAL into DR 0..NUM_REGS-1, requesters held off
// ST_RUN   | arbitrating A/B, one accepted write per cycle
module regfile_write_sched #(
  parameter int                NUM_REGS  = 8,
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 3,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input logic                  Clk,
  input logic                  Reset,
  regfile_write_sched_if.slave bus_if
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic              GRANT_A  = 1'b0;
  localparam logic              GRANT_B  = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic              r_last_grant;
  logic              r_ld;
  logic [ADDR_W-1:0] r_dr;
  logic [DATA_W-1:0] r_bus;
  logic              r_init_done;

  logic w_run;
  logic w_grant_a;
  logic w_grant_b;

  // Round-robin grant; a clear request outranks both requesters for the cycle.
  always_comb begin
    w_run     = (r_state == ST_RUN) && !bus_if.clear_req;
    w_grant_a = w_run && bus_if.a_valid && (!bus_if.b_valid || (r_last_grant == GRANT_B));
    w_grant_b = w_run && bus_if.b_valid && (!bus_if.a_valid || (r_last_grant == GRANT_A));
  end

  assign bus_if.a_ready   = w_grant_a;
  assign bus_if.b_ready   = w_grant_b;
  assign bus_if.LD_REG    = r_ld;
  assign bus_if.DR        = r_dr;
  assign bus_if.BUS       = r_bus;
  assign bus_if.init_done = r_init_done;

  // Sweep/run sequencing and the registered register-file load port.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state      <= ST_CLEAR;
      r_idx        <= '0;
      r_last_grant <= GRANT_B;
      r_ld         <= 1'b0;
      r_dr         <= '0;
      r_bus        <= '0;
      r_init_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_ld  <= 1'b1;
          r_dr  <= r_idx;
          r_bus <= CLEAR_VAL;
          if (r_idx == LAST_IDX) begin
            r_idx       <= '0;
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_RUN: begin
          if (bus_if.clear_req) begin
            r_ld        <= 1'b0;
            r_idx       <= '0;
            r_state     <= ST_CLEAR;
            r_init_done <= 1'b0;
          end else if (w_grant_a) begin
            r_ld         <= 1'b1;
            r_dr         <= bus_if.a_dr;
            r_bus        <= bus_if.a_data;
            r_last_grant <= GRANT_A;
          end else if (w_grant_b) begin
            r_ld         <= 1'b1;
            r_dr         <= bus_if.b_dr;
            r_bus        <= bus_if.b_data;
            r_last_grant <= GRANT_B;
          end else begin
            r_ld <= 1'b0;
          end
        end
        default: begin
          r_ld    <= 1'b0;
          r_idx   <= '0;
          r_state <= ST_CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_sched.sv
// Bench for the register-file write scheduler: directed scenarios followed by
// protocol-respecting random traffic, checked against a reference model.
module tb_regfile_write_sched;
  localparam int                NUM_REGS  = 8;
  localparam int                DATA_W    = 16;
  localparam int                ADDR_W    = 3;
  localparam logic [DATA_W-1:0] CLEAR_VAL = 16'h0000;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  regfile_write_sched_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

  regfile_write_sched #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .CLEAR_VAL(CLEAR_VAL)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus_if(bus_if)
  );

  int errors = 0;
  int checks = 0;

  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0]        ref_rf[NUM_REGS];
  logic [DATA_W-1:0]        dut_rf[NUM_REGS];

  bit m_clearing = 1'b1;
  int m_cnt      = 0;
  bit m_last_b   = 1'b1;
  bit m_init     = 1'b0;

  bit a_x, b_x;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: decides every cycle who should be granted and which
  // write the register file must see next cycle.
  always @(negedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_clearing = 1'b1;
      m_cnt      = 0;
      m_last_b   = 1'b1;
      m_init     = 1'b0;
      exp_q.delete();
    end else begin
      bit ea, eb;
      ea = 1'b0;
      eb = 1'b0;
      if (!m_clearing && !bus_if.clear_req) begin
        if (bus_if.a_valid && bus_if.b_valid) begin
          if (m_last_b) ea = 1'b1;
          else          eb = 1'b1;
        end else begin
          ea = bus_if.a_valid;
          eb = bus_if.b_valid;
        end
      end
      check("a_ready", bus_if.a_ready, ea);
      check("b_ready", bus_if.b_ready, eb);
      check("init_done", bus_if.init_done, m_init);
      if (m_clearing) begin
        exp_q.push_back({ADDR_W'(m_cnt), CLEAR_VAL});
        ref_rf[m_cnt] = CLEAR_VAL;
        m_cnt++;
        if (m_cnt == NUM_REGS) begin
          m_clearing = 1'b0;
          m_init     = 1'b1;
        end
      end else if (bus_if.clear_req) begin
        m_clearing = 1'b1;
        m_cnt      = 0;
        m_init     = 1'b0;
      end else if (ea) begin
        exp_q.push_back({bus_if.a_dr, bus_if.a_data});
        ref_rf[bus_if.a_dr] = bus_if.a_data;
        m_last_b = 1'b0;
      end else if (eb) begin
        exp_q.push_back({bus_if.b_dr, bus_if.b_data});
        ref_rf[bus_if.b_dr] = bus_if.b_data;
        m_last_b = 1'b1;
      end
    end
  end

  // Monitor: every load-port pulse must match the oldest expected write.
  always @(posedge Clk) begin
    logic [ADDR_W+DATA_W-1:0] e;
    #2;
    if (Reset) begin
      if (bus_if.LD_REG) begin
        dut_rf[bus_if.DR] = bus_if.BUS;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got DR=%0d BUS=%h expected no write", bus_if.DR, bus_if.BUS);
        end else begin
          e = exp_q.pop_front();
          check("write_dr", bus_if.DR, e[ADDR_W+DATA_W-1:DATA_W]);
          check("write_bus", bus_if.BUS, e[DATA_W-1:0]);
        end
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_write: got LD_REG=0 expected DR=%0d BUS=%h",
                 e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
      end
    end
  end

  // Records this cycle's transfers, then moves to just after the next edge.
  task automatic step();
    @(negedge Clk);
    a_x = bus_if.a_valid && bus_if.a_ready;
    b_x = bus_if.b_valid && bus_if.b_ready;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int na, nb, nz, a_t, b_t;
    bit got, found;

    bus_if.clear_req = 1'b0;
    bus_if.a_valid   = 1'b1;
    bus_if.a_dr      = '0;
    bus_if.a_data    = '0;
    bus_if.b_valid   = 1'b0;
    bus_if.b_dr      = '0;
    bus_if.b_data    = '0;
    #12;
    check("rst_ld", bus_if.LD_REG, 0);
    check("rst_dr", bus_if.DR, 0);
    check("rst_bus", bus_if.BUS, 0);
    check("rst_init", bus_if.init_done, 0);
    check("rst_a_ready", bus_if.a_ready, 0);
    check("rst_b_ready", bus_if.b_ready, 0);
    bus_if.a_valid = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b1;

    // Clear sweep after reset with no requests.
    repeat (12) step();
    check("t1_init_done", bus_if.init_done, 1);
    check("t1_ld_idle", bus_if.LD_REG, 0);

    // Single A write.
    bus_if.a_valid = 1'b1;
    bus_if.a_dr    = 3'd3;
    bus_if.a_data  = 16'hABCD;
    step();
    check("t2_accept", a_x, 1);
    bus_if.a_valid = 1'b0;
    repeat (3) step();

    // Both requesters valid continuously: grants must alternate.
    bus_if.a_valid = 1'b1; bus_if.a_dr = 3'd1; bus_if.a_data = 16'h1111;
    bus_if.b_valid = 1'b1; bus_if.b_dr = 3'd2; bus_if.b_data = 16'h2222;
    na = 0;
    nb = 0;
    repeat (8) begin
      step();
      na += int'(a_x);
      nb += int'(b_x);
    end
    check("t3_a_grants", na, 4);
    check("t3_b_grants", nb, 4);
    bus_if.a_valid = 1'b0;
    bus_if.b_valid = 1'b0;
    repeat (2) step();

    // clear_req beats a pending A write, which lands after the sweep.
    bus_if.clear_req = 1'b1;
    bus_if.a_valid = 1'b1; bus_if.a_dr = 3'd6; bus_if.a_data = 16'h1234;
    nz = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (i == 0) bus_if.clear_req = 1'b0;
      if (a_x) got = 1'b1;
      else     nz++;
    end
    check("t4_granted", got, 1);
    check("t4_ready_low_cycles", nz, 9);
    bus_if.a_valid = 1'b0;
    repeat (3) step();

    // Reset in the middle of a sweep.
    Reset = 1'b0;
    step();
    Reset = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (bus_if.LD_REG && bus_if.DR == 3'd4) found = 1'b1;
    end
    check("t5_reached_dr4", found, 1);
    Reset = 1'b0;
    #1;
    check("t5_async_ld", bus_if.LD_REG, 0);
    check("t5_async_dr", bus_if.DR, 0);
    check("t5_async_bus", bus_if.BUS, 0);
    check("t5_async_init", bus_if.init_done, 0);
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    step();
    check("t5_restart_ld", bus_if.LD_REG, 1);
    check("t5_restart_dr", bus_if.DR, 0);

    // Same destination from both requesters right after the sweep.
    for (int i = 0; i < 20 && !bus_if.init_done; i++) step();
    check("t6_init_done", bus_if.init_done, 1);
    bus_if.a_valid = 1'b1; bus_if.a_dr = 3'd5; bus_if.a_data = 16'hAAAA;
    bus_if.b_valid = 1'b1; bus_if.b_dr = 3'd5; bus_if.b_data = 16'hBBBB;
    a_t = -1;
    b_t = -1;
    for (int i = 0; i < 10 && (bus_if.a_valid || bus_if.b_valid); i++) begin
      step();
      if (a_x) begin a_t = i; bus_if.a_valid = 1'b0; end
      if (b_x) begin b_t = i; bus_if.b_valid = 1'b0; end
    end
    bus_if.a_valid = 1'b0;
    bus_if.b_valid = 1'b0;
    check("t6_both_granted", (a_t >= 0) && (b_t >= 0), 1);
    check("t6_a_first", a_t < b_t, 1);
    repeat (3) step();
    check("t6_r5_value", dut_rf[5], 16'hBBBB);
    check("t6_r5_model", dut_rf[5], ref_rf[5]);

    // Random traffic honouring the hold-while-not-ready rule.
    a_x = 1'b0;
    b_x = 1'b0;
    repeat (400) begin
      if (!(bus_if.a_valid && !a_x)) begin
        bus_if.a_valid = 1'($urandom_range(0, 1));
        bus_if.a_dr    = ADDR_W'($urandom);
        bus_if.a_data  = DATA_W'($urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        bus_if.a_valid = 1'b0;
      end
      if (!(bus_if.b_valid && !b_x)) begin
        bus_if.b_valid = 1'($urandom_range(0, 1));
        bus_if.b_dr    = ADDR_W'($urandom);
        bus_if.b_data  = DATA_W'($urandom);
      end else if ($urandom_range(0, 7) == 0) begin
        bus_if.b_valid = 1'b0;
      end
      bus_if.clear_req = ($urandom_range(0, 39) == 0);
      step();
    end
    bus_if.a_valid   = 1'b0;
    bus_if.b_valid   = 1'b0;
    bus_if.clear_req = 1'b0;
    repeat (12) step();
    check("final_queue_empty", exp_q.size(), 0);
    for (int r = 0; r < NUM_REGS; r++) check("final_rf", dut_rf[r], ref_rf[r]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
